lorenz_deriv_engine: RTL

Computes the three Lorenz derivative increments (dt·dx/dt, dt·dy/dt, dt·dz/dt) from the current state (x, y, z). It is the producer side of the state-integrator interface: it consumes the integrators' state outputs and supplies their increment inputs. One shared fixed-point multiplier is sequenced by an FSM under a start/done handshake. The top level advances the integrators only on done.

---
 rtl/lorenz_pkg.sv | 50 +++++
 rtl/lorenz_deriv_engine_fx_mul_q.sv | 15 +
 rtl/lorenz_deriv_engine.sv | 121 ++++++++++++
 3 files changed

// File: rtl/lorenz_pkg.sv
// Shared constants, FSM state type and WIDTH-reduction helpers for the Lorenz derivative engine.
// Build option LORENZ_SAT_EN selects saturating reduction; otherwise reductions wrap.
package lorenz_pkg;

    localparam int unsigned WIDTH    = 27;
    localparam int unsigned FRAC     = 20;
    localparam int unsigned DT_SHIFT = 8;
    localparam int unsigned PW       = 2 * WIDTH;
    localparam int unsigned DW       = WIDTH + 1;

    localparam logic signed [WIDTH-1:0] SIGMA_Q = WIDTH'(10485760);
    localparam logic signed [WIDTH-1:0] RHO_Q   = WIDTH'(29360128);
    localparam logic signed [WIDTH-1:0] BETA_Q  = WIDTH'(2796203);

    localparam logic signed [PW-1:0] RED_MAX = PW'(64'sd67108863);
    localparam logic signed [PW-1:0] RED_MIN = PW'(-64'sd67108864);

    typedef enum logic [2:0] {
        S_IDLE,
        S_M1,
        S_M2,
        S_M3,
        S_M4,
        S_WB
    } state_t;

    // Bring a wide signed value back to WIDTH bits.
    function automatic logic signed [WIDTH-1:0] reduce(input logic signed [PW-1:0] v);
`ifdef LORENZ_SAT_EN
        if (v > RED_MAX) begin
            return RED_MAX[WIDTH-1:0];
        end
        if (v < RED_MIN) begin
            return RED_MIN[WIDTH-1:0];
        end
        return v[WIDTH-1:0];
`else
        return v[WIDTH-1:0];
`endif
    endfunction

    // a - b evaluated one bit wider so the true difference exists before reduction.
    function automatic logic signed [WIDTH-1:0] sub_reduce(input logic signed [WIDTH-1:0] a,
                                                           input logic signed [WIDTH-1:0] b);
        logic signed [DW-1:0] d;
        d = DW'(a) - DW'(b);
        return reduce(PW'(d));
    endfunction

endpackage

// File: rtl/lorenz_deriv_engine_fx_mul_q.sv
// Combinational signed Q6.20 multiply: full-width product, floor shift by FRAC, reduce to WIDTH.
module fx_mul_q
    import lorenz_pkg::*;
(
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p_c
);

    logic signed [PW-1:0] prod_c;

    assign prod_c = PW'(a) * PW'(b);
    assign p_c    = reduce(prod_c >>> FRAC);

endmodule

// File: rtl/lorenz_deriv_engine.sv
// Lorenz derivative increments via one shared multiplier sequenced IDLE->M1..M4->WB.
// LORENZ_SAT_EN (see lorenz_pkg) switches every WIDTH reduction from wrap to saturate.
module lorenz_deriv_engine
    import lorenz_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic signed [WIDTH-1:0] dx_out,
    output logic signed [WIDTH-1:0] dy_out,
    output logic signed [WIDTH-1:0] dz_out,
    output logic                    busy,
    output logic                    done
);

    state_t                  state;
    logic signed [WIDTH-1:0] x_q, y_q, z_q;
    logic signed [WIDTH-1:0] p0, p1, p2, p3;
    logic signed [WIDTH-1:0] mul_a_c, mul_b_c, mul_p_c;
    logic signed [WIDTH-1:0] dy_diff_c, dz_diff_c;

    // Operand steering for the single multiplier.
    always_comb begin
        mul_a_c = '0;
        mul_b_c = '0;
        case (state)
            S_M1: begin
                mul_a_c = SIGMA_Q;
                mul_b_c = sub_reduce(y_q, x_q);
            end
            S_M2: begin
                mul_a_c = x_q;
                mul_b_c = sub_reduce(RHO_Q, z_q);
            end
            S_M3: begin
                mul_a_c = x_q;
                mul_b_c = y_q;
            end
            S_M4: begin
                mul_a_c = BETA_Q;
                mul_b_c = z_q;
            end
            default: begin
                mul_a_c = '0;
                mul_b_c = '0;
            end
        endcase
    end

    fx_mul_q u_mul (
        .a   (mul_a_c),
        .b   (mul_b_c),
        .p_c (mul_p_c)
    );

    assign dy_diff_c = sub_reduce(p1, y_q);
    assign dz_diff_c = sub_reduce(p2, p3);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            p0     <= '0;
            p1     <= '0;
            p2     <= '0;
            p3     <= '0;
            dx_out <= '0;
            dy_out <= '0;
            dz_out <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_q   <= x_in;
                        y_q   <= y_in;
                        z_q   <= z_in;
                        busy  <= 1'b1;
                        state <= S_M1;
                    end
                end
                S_M1: begin
                    p0    <= mul_p_c;
                    state <= S_M2;
                end
                S_M2: begin
                    p1    <= mul_p_c;
                    state <= S_M3;
                end
                S_M3: begin
                    p2    <= mul_p_c;
                    state <= S_M4;
                end
                S_M4: begin
                    p3    <= mul_p_c;
                    state <= S_WB;
                end
                S_WB: begin
                    dx_out <= p0 >>> DT_SHIFT;
                    dy_out <= dy_diff_c >>> DT_SHIFT;
                    dz_out <= dz_diff_c >>> DT_SHIFT;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
